div_sqrt_result_queue: RTL

- Flow-control and result-capture stage wrapped around divSqrtRecFN.
- Gates issue into the unit with a credit check, remembers the tag of the single in-flight operation, and captures each result pulse (out, exceptionFlags, sqrtOpOut) into a small FIFO.
- Presents results to the consumer on a valid/ready interface.
- Needed because the unit's outValid is a one-cycle pulse with no backpressure; operand/rounding buses go straight to the unit and do not pass through this block.

---
 rtl/div_sqrt_pkg.sv | 36 +++
 rtl/div_sqrt_result_fifo.sv | 64 ++++++
 rtl/div_sqrt_result_queue.sv | 114 +++++++++++
 3 files changed

// File: rtl/div_sqrt_pkg.sv
// rtl/div_sqrt_pkg.sv - result-entry layout and exception-flag positions for div_sqrt_result_queue
//
// Purpose: shared widths and offsets of a queued result entry, derived from
// the recoded-format exponent/significand widths and the tag width.
// Entry layout, MSB to LSB: {tag, sqrt_op, out, exception_flags}.
// Ports: none (package).

package div_sqrt_pkg;

  localparam int FLAG_W        = 5;
  localparam int FLAG_INEXACT  = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW = 2;
  localparam int FLAG_INFINITE = 3;
  localparam int FLAG_INVALID  = 4;

  localparam int FLAGS_LSB = 0;
  localparam int OUT_LSB   = FLAGS_LSB + FLAG_W;

  function automatic int out_width(int exp_w, int sig_w);
    return exp_w + sig_w + 1;
  endfunction

  function automatic int sqrt_pos(int exp_w, int sig_w);
    return OUT_LSB + out_width(exp_w, sig_w);
  endfunction

  function automatic int tag_lsb(int exp_w, int sig_w);
    return sqrt_pos(exp_w, sig_w) + 1;
  endfunction

  function automatic int entry_width(int exp_w, int sig_w, int tag_w);
    return tag_lsb(exp_w, sig_w) + tag_w;
  endfunction

endpackage

// File: rtl/div_sqrt_result_fifo.sv
// rtl/div_sqrt_result_fifo.sv - synchronous width/depth FIFO with occupancy output
//
// Purpose: stores captured results in arrival order; head is read
// combinationally from storage so it holds stable until popped.
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous active-high reset (pointers and count only)
//   wr_en    in   push wr_data
//   wr_data  in   WIDTH-bit entry
//   rd_en    in   pop head (caller guarantees count != 0)
//   rd_data  out  head entry
//   count    out  occupancy, 0..DEPTH

module div_sqrt_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(wr_en && count == CW'(DEPTH)));
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/div_sqrt_result_queue.sv
// rtl/div_sqrt_result_queue.sv - credit-gated issue and result capture around divSqrtRecFN
//
// Purpose: admits an operation only when a FIFO slot is guaranteed for its
// result, remembers the tag of the single in-flight operation, and queues each
// outValid pulse so the consumer can apply backpressure.
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   req_valid/req_ready/req_tag  upstream issue handshake and tag
//   unit_inReady/unit_inValid    divSqrtRecFN issue handshake
//   unit_outValid, unit_sqrtOpOut, unit_out, unit_exceptionFlags
//                                divSqrtRecFN result pulse and fields
//   resp_valid/resp_ready        consumer handshake on the FIFO head
//   resp_tag, resp_sqrtOp, resp_out, resp_exceptionFlags
//                                head entry fields
//   err_spurious                 sticky: result pulse with nothing in flight

module div_sqrt_result_queue
  import div_sqrt_pkg::*;
#(
  parameter int expWidth = 8,
  parameter int sigWidth = 24,
  parameter int tagWidth = 4,
  parameter int depth    = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [tagWidth-1:0]          req_tag,
  input  logic                         unit_inReady,
  output logic                         unit_inValid,
  input  logic                         unit_outValid,
  input  logic                         unit_sqrtOpOut,
  input  logic [expWidth+sigWidth:0]   unit_out,
  input  logic [4:0]                   unit_exceptionFlags,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [tagWidth-1:0]          resp_tag,
  output logic                         resp_sqrtOp,
  output logic [expWidth+sigWidth:0]   resp_out,
  output logic [4:0]                   resp_exceptionFlags,
  output logic                         err_spurious
);

  localparam int OW = out_width(expWidth, sigWidth);
  localparam int EW = entry_width(expWidth, sigWidth, tagWidth);
  localparam int SP = sqrt_pos(expWidth, sigWidth);
  localparam int TL = tag_lsb(expWidth, sigWidth);
  localparam int CW = $clog2(depth) + 1;
  localparam int SW = CW + 1;

  logic                inflight;
  logic [tagWidth-1:0] inflight_tag;
  logic [CW-1:0]       occupancy;
  logic                credit_ok;
  logic                issue;
  logic                capture;
  logic                dequeue;
  logic [EW-1:0]       wr_entry;
  logic [EW-1:0]       head;

  // Credit counts the in-flight op as already holding a slot, so its result
  // can never find the FIFO full. Registered state only: a pop frees credit
  // one cycle later.
  assign credit_ok    = ({1'b0, occupancy} + SW'(inflight)) < SW'(depth);
  assign req_ready    = unit_inReady & credit_ok & ~reset;
  assign unit_inValid = req_valid & req_ready;
  assign issue        = unit_inValid;

  // inflight_tag is read before the same-cycle issue overwrites it, so a
  // turnover cycle captures the old operation's tag.
  assign capture  = unit_outValid & inflight;
  assign wr_entry = {inflight_tag, unit_sqrtOpOut, unit_out, unit_exceptionFlags};

  assign resp_valid = (occupancy != '0);
  assign dequeue    = resp_valid & resp_ready;

  assign resp_tag            = head[TL +: tagWidth];
  assign resp_sqrtOp         = head[SP];
  assign resp_out            = head[OUT_LSB +: OW];
  assign resp_exceptionFlags = head[FLAGS_LSB +: FLAG_W];

  div_sqrt_result_fifo #(
    .WIDTH (EW),
    .DEPTH (depth)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (capture),
    .wr_data (wr_entry),
    .rd_en   (dequeue),
    .rd_data (head),
    .count   (occupancy)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight     <= 1'b0;
      inflight_tag <= '0;
      err_spurious <= 1'b0;
    end else begin
      if (issue) begin
        inflight     <= 1'b1;
        inflight_tag <= req_tag;
      end else if (unit_outValid) begin
        inflight <= 1'b0;
      end
      if (unit_outValid && !inflight) begin
        err_spurious <= 1'b1;
      end
    end
  end

endmodule
